// File: rtl/axi_interface_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_interface_master
// Purpose  : Single-outstanding AXI4 master bridge. Each core request becomes
//            one AXI burst (AW/W/B for writes, AR/R for reads). Write and
//            read data are combinational pass-through streams. Completion is
//            reported as a one-cycle resp_valid pulse with resp_err.
// Options  : AXI_MASTER_LAST_CHECK_EN - count R beats, check rlast against
//            the requested length and rid against MASTER_ID.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef LEN_BITS
`define LEN_BITS 8
`endif
`ifndef SIZE_BITS
`define SIZE_BITS 3
`endif
`ifndef ID_BITS
`define ID_BITS 4
`endif
`ifndef RESP_OKAY
`define RESP_OKAY 3'b000
`endif

module axi_interface_master #(
   parameter logic [`ID_BITS-1:0] MASTER_ID = '0
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   // core request
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_we,
   input  logic [`ADDR_WIDTH-1:0]    req_addr,
   input  logic [`LEN_BITS-1:0]      req_len,
   input  logic [`SIZE_BITS-1:0]     req_size,
   input  logic [1:0]                req_burst,
   // core write stream
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [`DATA_WIDTH-1:0]    wr_data,
   input  logic [`DATA_WIDTH/8-1:0]  wr_strb,
   // core read stream
   output logic                      rd_valid,
   input  logic                      rd_ready,
   output logic [`DATA_WIDTH-1:0]    rd_data,
   output logic                      rd_last,
   // completion
   output logic                      resp_valid,
   output logic                      resp_err,
   // AXI AW
   output logic [`ID_BITS-1:0]       awid,
   output logic [`ADDR_WIDTH-1:0]    awaddr,
   output logic [`LEN_BITS-1:0]      awlen,
   output logic [`SIZE_BITS-1:0]     awsize,
   output logic [1:0]                awburst,
   output logic                      awvalid,
   input  logic                      awready,
   // AXI W
   output logic [`DATA_WIDTH-1:0]    wdata,
   output logic [`DATA_WIDTH/8-1:0]  wstrb,
   output logic                      wlast,
   output logic                      wvalid,
   input  logic                      wready,
   // AXI B
   input  logic [`ID_BITS-1:0]       bid,
   input  logic [2:0]                bresp,
   input  logic                      bvalid,
   output logic                      bready,
   // AXI AR
   output logic [`ID_BITS-1:0]       arid,
   output logic [`ADDR_WIDTH-1:0]    araddr,
   output logic [`LEN_BITS-1:0]      arlen,
   output logic [`SIZE_BITS-1:0]     arsize,
   output logic [1:0]                arburst,
   output logic                      arvalid,
   input  logic                      arready,
   // AXI R
   input  logic [`ID_BITS-1:0]       rid,
   input  logic [`DATA_WIDTH-1:0]    rdata,
   input  logic [2:0]                rresp,
   input  logic                      rlast,
   input  logic                      rvalid,
   output logic                      rready
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_ADDR = 3'd1,
      WR_DATA = 3'd2,
      WR_RESP = 3'd3,
      RD_ADDR = 3'd4,
      RD_DATA = 3'd5
   } state_t;

   state_t                   state_q, state_d;
   logic [`ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [`LEN_BITS-1:0]     len_q, len_d;
   logic [`SIZE_BITS-1:0]    size_q, size_d;
   logic [1:0]               burst_q, burst_d;
   logic [`LEN_BITS-1:0]     beat_cnt_q, beat_cnt_d;
   logic                     err_q, err_d;

   logic w_cnt_last;   // current beat is the final one of the request
   logic w_rd_done;    // this R beat, if accepted, ends the burst
   logic w_beat_err;   // this R beat carries an error
   logic w_len_err;    // rlast disagrees with the requested length
   logic w_rd_count;   // read beats advance the beat counter
   logic w_unused;

   assign w_cnt_last = (beat_cnt_q == len_q);

`ifdef AXI_MASTER_LAST_CHECK_EN
   // Terminate on whichever comes first: rlast or the final counted beat;
   // any disagreement between the two is reported as an error.
   assign w_rd_done  = rlast | w_cnt_last;
   assign w_beat_err = (rresp != `RESP_OKAY) | (rid != MASTER_ID);
   assign w_len_err  = rlast ^ w_cnt_last;
   assign w_rd_count = 1'b1;
   assign w_unused   = ^bid;
`else
   // Slave's rlast alone ends the burst; rid is not inspected.
   assign w_rd_done  = rlast;
   assign w_beat_err = (rresp != `RESP_OKAY);
   assign w_len_err  = 1'b0;
   assign w_rd_count = 1'b0;
   assign w_unused   = ^{bid, rid};
`endif

   // Address channels always reflect the registered request, so they stay
   // stable for the whole burst regardless of core-side activity.
   assign awid    = MASTER_ID;
   assign awaddr  = addr_q;
   assign awlen   = len_q;
   assign awsize  = size_q;
   assign awburst = burst_q;
   assign arid    = MASTER_ID;
   assign araddr  = addr_q;
   assign arlen   = len_q;
   assign arsize  = size_q;
   assign arburst = burst_q;
   assign wdata   = wr_data;
   assign wstrb   = wr_strb;
   assign rd_data = rdata;

   // Next-state logic and handshake outputs for the burst sequencer
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      len_d      = len_q;
      size_d     = size_q;
      burst_d    = burst_q;
      beat_cnt_d = beat_cnt_q;
      err_d      = err_q;
      req_ready  = 1'b0;
      awvalid    = 1'b0;
      wvalid     = 1'b0;
      wr_ready   = 1'b0;
      wlast      = 1'b0;
      bready     = 1'b0;
      arvalid    = 1'b0;
      rready     = 1'b0;
      rd_valid   = 1'b0;
      rd_last    = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               addr_d     = req_addr;
               len_d      = req_len;
               size_d     = req_size;
               burst_d    = req_burst;
               beat_cnt_d = '0;
               err_d      = 1'b0;
               state_d    = req_we ? WR_ADDR : RD_ADDR;
            end
         end
         WR_ADDR: begin
            awvalid = 1'b1;
            if (awready) state_d = WR_DATA;
         end
         WR_DATA: begin
            wvalid   = wr_valid;
            wr_ready = wready;
            wlast    = w_cnt_last;
            if (wr_valid && wready) begin
               // Counter stops on the last beat so a full-length burst
               // finishes at the all-ones count without wrapping.
               if (w_cnt_last) state_d    = WR_RESP;
               else            beat_cnt_d = beat_cnt_q + 1'b1;
            end
         end
         WR_RESP: begin
            bready = 1'b1;
            if (bvalid) begin
               resp_valid = 1'b1;
               resp_err   = (bresp != `RESP_OKAY);
               state_d    = IDLE;
            end
         end
         RD_ADDR: begin
            arvalid = 1'b1;
            if (arready) state_d = RD_DATA;
         end
         RD_DATA: begin
            rd_valid = rvalid;
            rready   = rd_ready;
            rd_last  = w_rd_done;
            if (rvalid && rd_ready) begin
               err_d = err_q | w_beat_err;
               if (w_rd_done) begin
                  resp_valid = 1'b1;
                  resp_err   = err_q | w_beat_err | w_len_err;
                  state_d    = IDLE;
               end else if (w_rd_count) begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and request registers; reset abandons any burst in flight
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         size_q     <= '0;
         burst_q    <= '0;
         beat_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         size_q     <= size_d;
         burst_q    <= burst_d;
         beat_cnt_q <= beat_cnt_d;
         err_q      <= err_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_axi_interface_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_interface_master
// Purpose  : Randomized self-checking bench for axi_interface_master with a
//            behavioural AXI slave and burst-level expectation model.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef LEN_BITS
`define LEN_BITS 8
`endif
`ifndef SIZE_BITS
`define SIZE_BITS 3
`endif
`ifndef ID_BITS
`define ID_BITS 4
`endif
`ifndef RESP_OKAY
`define RESP_OKAY 3'b000
`endif

module tb_axi_interface_master;
   localparam int AW = `ADDR_WIDTH;
   localparam int DW = `DATA_WIDTH;
   localparam int LW = `LEN_BITS;
   localparam int SW = `SIZE_BITS;
   localparam int IW = `ID_BITS;
   localparam logic [IW-1:0] MID = IW'(5);

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic rst_i;
   logic req_valid, req_ready, req_we;
   logic [AW-1:0] req_addr;
   logic [LW-1:0] req_len;
   logic [SW-1:0] req_size;
   logic [1:0]    req_burst;
   logic wr_valid, wr_ready;
   logic [DW-1:0]   wr_data;
   logic [DW/8-1:0] wr_strb;
   logic rd_valid, rd_ready, rd_last;
   logic [DW-1:0] rd_data;
   logic resp_valid, resp_err;
   logic [IW-1:0] awid, arid, bid, rid;
   logic [AW-1:0] awaddr, araddr;
   logic [LW-1:0] awlen, arlen;
   logic [SW-1:0] awsize, arsize;
   logic [1:0]    awburst, arburst;
   logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic arvalid, arready, rlast, rvalid, rready;
   logic [DW-1:0]   wdata, rdata;
   logic [DW/8-1:0] wstrb;
   logic [2:0] bresp, rresp;

   int tests_run    = 0;
   int tests_failed = 0;

   axi_interface_master #(.MASTER_ID(MID)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_len(req_len), .req_size(req_size), .req_burst(req_burst),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .resp_valid(resp_valid), .resp_err(resp_err),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid = 0; req_we = 0; req_addr = '0; req_len = '0; req_size = '0; req_burst = '0;
      wr_valid = 0; wr_data = '0; wr_strb = '0; rd_ready = 0;
      awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0;
      arready = 0; rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
   endtask

   task automatic scramble_req();
      req_addr  = AW'($urandom);
      req_len   = LW'($urandom);
      req_size  = SW'($urandom);
      req_burst = 2'($urandom);
      req_we    = 1'($urandom);
   endtask

   // One write burst. bp_mode stalls beats 0 and 2 for two cycles each.
   task automatic run_write(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                            input logic [SW-1:0] size, input logic [1:0] burst,
                            input int aw_delay, input int wstall, input bit bp_mode,
                            input logic [2:0] bresp_v, input bit hold_req);
      logic [DW-1:0] d; logic [DW/8-1:0] s;
      bit hs, to, exp_err;
      int n, bd;
      n = int'(len) + 1;
      to = 0;
      req_valid = 1; req_we = 1; req_addr = addr; req_len = len; req_size = size; req_burst = burst;
      #1;
      tests_run++;
      if (req_ready !== 1'b1) begin
         tests_failed++; $display("FAIL wr_req_ready: got %b exp 1", req_ready);
      end
      tick();
      if (!hold_req) req_valid = 0;
      scramble_req();
      #1;
      tests_run++;
      if ({awvalid, awid, awaddr, awlen, awsize, awburst, arvalid, req_ready} !==
          {1'b1, MID, addr, len, size, burst, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL aw_fields: got %h exp %h",
                  {awvalid, awid, awaddr, awlen, awsize, awburst, arvalid, req_ready},
                  {1'b1, MID, addr, len, size, burst, 1'b0, 1'b0});
      end
      for (int i = 0; i < aw_delay; i++) begin
         awready = 0; bvalid = 1'($urandom); rvalid = 1'($urandom); wr_valid = 1'($urandom);
         #1;
         tests_run++;
         if ({awvalid, awaddr, awlen, bready, rready, wvalid, rd_valid, resp_valid} !==
             {1'b1, addr, len, 5'b0}) begin
            tests_failed++;
            $display("FAIL aw_stall: got %h exp %h",
                     {awvalid, awaddr, awlen, bready, rready, wvalid, rd_valid, resp_valid},
                     {1'b1, addr, len, 5'b0});
         end
         tick();
      end
      bvalid = 0; rvalid = 0; wr_valid = 0; awready = 1;
      tick();
      awready = 0;
      for (int b = 0; b < n && !to; b++) begin
         d = DW'($urandom); s = (DW/8)'($urandom); hs = 0;
         for (int cyc = 0; cyc < 100 && !hs; cyc++) begin
            wr_data = d; wr_strb = s;
            if (bp_mode) begin
               wr_valid = 1;
               wready   = !((b == 0 || b == 2) && cyc < 2);
            end else begin
               wr_valid = ($urandom % 4) != 0;
               wready   = ($urandom % 100) >= wstall;
            end
            #1;
            tests_run++;
            if ({wvalid, wr_ready, wdata, wstrb, wlast, bready, awvalid, resp_valid} !==
                {wr_valid, wready, d, s, (b == n - 1), 3'b0}) begin
               tests_failed++;
               $display("FAIL w_beat%0d: got %h exp %h", b,
                        {wvalid, wr_ready, wdata, wstrb, wlast, bready, awvalid, resp_valid},
                        {wr_valid, wready, d, s, (b == n - 1), 3'b0});
            end
            hs = wr_valid && wready;
            tick();
         end
         if (!hs) begin
            to = 1; tests_run++; tests_failed++;
            $display("FAIL w_timeout: beat %0d never accepted", b);
         end
      end
      wr_valid = 0; wready = 0;
      bd = $urandom_range(2, 0);
      for (int i = 0; i < bd; i++) begin
         #1;
         tests_run++;
         if ({bready, resp_valid, resp_err, wvalid} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL b_wait: got %b exp 1000", {bready, resp_valid, resp_err, wvalid});
         end
         tick();
      end
      req_valid = 0;
      bvalid = 1; bresp = bresp_v; bid = MID;
      exp_err = (bresp_v != `RESP_OKAY);
      #1;
      tests_run++;
      if ({bready, resp_valid, resp_err} !== {1'b1, 1'b1, exp_err}) begin
         tests_failed++;
         $display("FAIL b_resp: got %b exp %b", {bready, resp_valid, resp_err}, {1'b1, 1'b1, exp_err});
      end
      tick();
      bvalid = 0; bresp = '0;
      #1;
      tests_run++;
      if ({req_ready, resp_valid, resp_err, awvalid, bready} !== 5'b10000) begin
         tests_failed++;
         $display("FAIL wr_done_idle: got %b exp 10000", {req_ready, resp_valid, resp_err, awvalid, bready});
      end
   endtask

   // One read burst. Slave raises rlast on beat rlast_beat, errors on
   // err_beat, drives a wrong rid on bad_rid_beat (-1 disables each).
   task automatic run_read(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                           input logic [SW-1:0] size, input logic [1:0] burst,
                           input int ar_delay, input bit toggle_mode,
                           input int err_beat, input int rlast_beat, input int bad_rid_beat);
      logic [DW-1:0] d;
      bit hs, to, exp_err, tog, fin;
      int n, term;
      n = int'(len) + 1;
      to = 0; tog = 0;
`ifdef AXI_MASTER_LAST_CHECK_EN
      term    = (rlast_beat < n - 1) ? rlast_beat : n - 1;
      exp_err = (err_beat >= 0 && err_beat <= term) ||
                (bad_rid_beat >= 0 && bad_rid_beat <= term) || (rlast_beat != n - 1);
`else
      term    = rlast_beat;
      exp_err = (err_beat >= 0 && err_beat <= term);
`endif
      req_valid = 1; req_we = 0; req_addr = addr; req_len = len; req_size = size; req_burst = burst;
      #1;
      tests_run++;
      if (req_ready !== 1'b1) begin
         tests_failed++; $display("FAIL rd_req_ready: got %b exp 1", req_ready);
      end
      tick();
      req_valid = 0;
      scramble_req();
      #1;
      tests_run++;
      if ({arvalid, arid, araddr, arlen, arsize, arburst, awvalid, req_ready} !==
          {1'b1, MID, addr, len, size, burst, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL ar_fields: got %h exp %h",
                  {arvalid, arid, araddr, arlen, arsize, arburst, awvalid, req_ready},
                  {1'b1, MID, addr, len, size, burst, 1'b0, 1'b0});
      end
      for (int i = 0; i < ar_delay; i++) begin
         arready = 0; rvalid = 1'($urandom); bvalid = 1'($urandom); rd_ready = 1'($urandom);
         #1;
         tests_run++;
         if ({arvalid, araddr, rready, rd_valid, bready, resp_valid} !== {1'b1, addr, 4'b0}) begin
            tests_failed++;
            $display("FAIL ar_stall: got %h exp %h",
                     {arvalid, araddr, rready, rd_valid, bready, resp_valid}, {1'b1, addr, 4'b0});
         end
         tick();
      end
      rvalid = 0; bvalid = 0; rd_ready = 0; arready = 1;
      tick();
      arready = 0;
      for (int b = 0; b <= term && !to; b++) begin
         d = DW'($urandom); hs = 0;
         for (int cyc = 0; cyc < 100 && !hs; cyc++) begin
            rdata = d;
            rlast = (b == rlast_beat);
            rresp = (b == err_beat) ? 3'd2 : 3'd0;
            rid   = (b == bad_rid_beat) ? ~MID : MID;
            rvalid = ($urandom % 4) != 0;
            if (toggle_mode) begin rd_ready = tog; tog = !tog; end
            else rd_ready = 1'($urandom);
            #1;
            hs  = rvalid && rd_ready;
            fin = hs && (b == term);
            tests_run++;
            if ({rd_valid, rready, rd_data, rd_last, resp_valid, resp_err, arvalid} !==
                {rvalid, rd_ready, d, (b == term), fin, fin & exp_err, 1'b0}) begin
               tests_failed++;
               $display("FAIL r_beat%0d: got %h exp %h", b,
                        {rd_valid, rready, rd_data, rd_last, resp_valid, resp_err, arvalid},
                        {rvalid, rd_ready, d, (b == term), fin, fin & exp_err, 1'b0});
            end
            tick();
         end
         if (!hs) begin
            to = 1; tests_run++; tests_failed++;
            $display("FAIL r_timeout: beat %0d never accepted", b);
         end
      end
      rvalid = 0; rlast = 0; rd_ready = 0; rresp = '0; rid = '0;
      #1;
      tests_run++;
      if ({req_ready, resp_valid, resp_err, arvalid, rready} !== 5'b10000) begin
         tests_failed++;
         $display("FAIL rd_done_idle: got %b exp 10000", {req_ready, resp_valid, resp_err, arvalid, rready});
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_i = 1;
      wr_valid = 1; rvalid = 1; bvalid = 1; rd_ready = 1; wready = 1;
      tick(); tick();
      tests_run++;
      if ({req_ready, awvalid, wvalid, wr_ready, wlast, bready, arvalid, rready, rd_valid,
           rd_last, resp_valid, resp_err} !== 12'b1000_0000_0000) begin
         tests_failed++;
         $display("FAIL reset_state: got %b exp 100000000000",
                  {req_ready, awvalid, wvalid, wr_ready, wlast, bready, arvalid, rready, rd_valid,
                   rd_last, resp_valid, resp_err});
      end
      idle_inputs();
      rst_i = 0;
      #1;
      tests_run++;
      if ({req_ready, awvalid, arvalid, bready, rready, resp_valid} !== 6'b100000) begin
         tests_failed++;
         $display("FAIL post_reset: got %b exp 100000",
                  {req_ready, awvalid, arvalid, bready, rready, resp_valid});
      end
   endtask

   task automatic test_single_write();
      run_write(AW'(32'h100), '0, SW'(2), 2'b01, 0, 0, 0, 3'd0, 0);
   endtask

   task automatic test_incr_read_stalls();
      run_read(AW'(32'h40), LW'(3), SW'(2), 2'b01, 0, 1, -1, 3, -1);
   endtask

   task automatic test_backpressure();
      run_write(AW'($urandom), LW'(3), SW'(2), 2'b01, 5, 0, 1, 3'd0, 0);
   endtask

   task automatic test_error_resp();
      run_write(AW'($urandom), LW'(1), SW'(2), 2'b01, 1, 30, 0, 3'd2, 0);
      run_read(AW'($urandom), LW'(3), SW'(2), 2'b01, 1, 0, 1, 3, -1);
   endtask

   task automatic test_reset_mid_burst();
      req_valid = 1; req_we = 1; req_addr = AW'($urandom); req_len = LW'(7);
      req_size = SW'(2); req_burst = 2'b01;
      tick();
      req_valid = 0; awready = 1;
      tick();
      awready = 0; wr_valid = 1; wready = 1; wr_data = DW'($urandom);
      tick();
      rst_i = 1;
      #1;
      tests_run++;
      if ({wvalid, wr_ready, wlast} !== 3'b110) begin
         tests_failed++;
         $display("FAIL mid_beat2: got %b exp 110", {wvalid, wr_ready, wlast});
      end
      tick();
      rst_i = 0; bvalid = 1; rvalid = 1; rd_ready = 1;
      #1;
      tests_run++;
      if ({awvalid, wvalid, bready, req_ready, arvalid, rready, rd_valid, resp_valid} !== 8'b0001_0000) begin
         tests_failed++;
         $display("FAIL mid_reset: got %b exp 00010000",
                  {awvalid, wvalid, bready, req_ready, arvalid, rready, rd_valid, resp_valid});
      end
      idle_inputs();
      run_read(AW'($urandom), LW'(2), SW'(2), 2'b01, 0, 0, -1, 2, -1);
   endtask

   task automatic test_back_to_back();
      run_write(AW'($urandom), LW'(2), SW'(2), 2'b01, 0, 0, 0, 3'd0, 1);
      run_read(AW'($urandom), LW'(2), SW'(2), 2'b10, 0, 0, -1, 2, -1);
      run_write(AW'($urandom), LW'(0), SW'(1), 2'b00, 0, 0, 0, 3'd0, 1);
   endtask

   task automatic test_max_len();
      run_write(AW'($urandom), LW'((1 << LW) - 1), SW'(2), 2'b01, 0, 10, 0, 3'd0, 0);
      run_read(AW'($urandom), LW'((1 << LW) - 1), SW'(2), 2'b01, 0, 0, -1, (1 << LW) - 1, -1);
   endtask

   task automatic test_random();
      logic [LW-1:0] l;
      int eb;
      for (int i = 0; i < 16; i++) begin
         l  = (($urandom % 4) == 0) ? LW'($urandom % 16) : LW'($urandom % 4);
         eb = (($urandom % 3) == 0) ? int'($urandom_range(int'(l), 0)) : -1;
         if ($urandom % 2)
            run_write(AW'($urandom), l, SW'($urandom), 2'($urandom), $urandom_range(3, 0),
                      $urandom_range(60, 0), 0, (($urandom % 3) == 0) ? 3'($urandom_range(3, 1)) : 3'd0,
                      1'($urandom));
         else
            run_read(AW'($urandom), l, SW'($urandom), 2'($urandom), $urandom_range(3, 0),
                     1'($urandom), eb, int'(l), -1);
      end
   endtask

`ifdef AXI_MASTER_LAST_CHECK_EN
   task automatic test_last_check();
      run_read(AW'(32'h40), LW'(3), SW'(2), 2'b01, 0, 0, -1, 1, -1);
      run_read(AW'($urandom), LW'(1), SW'(2), 2'b01, 0, 0, -1, 99, -1);
      run_read(AW'($urandom), LW'(2), SW'(2), 2'b01, 0, 0, -1, 2, 1);
   endtask
`endif

   initial begin
      idle_inputs();
      rst_i = 1;
      test_reset();
      test_single_write();
      test_incr_read_stalls();
      test_backpressure();
      test_error_resp();
      test_reset_mid_burst();
      test_back_to_back();
      test_max_len();
      test_random();
`ifdef AXI_MASTER_LAST_CHECK_EN
      test_last_check();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

`default_nettype wire
